// File: rtl/uart_pkg.sv
// UART shared types: transmit FSM states and parity mode encodings.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

endpackage

// File: rtl/uart_tx_frame_if.sv
// Producer-side word handshake into the UART transmitter.
// Latency: none (wires only).
// Backpressure: tx_ready low while the transmitter's holding register is full.
interface uart_tx_frame_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_bit_timer.sv
// Bit-period counter 0..OVERSAMPLE-1 with start-of-bit / end-of-bit strobes.
// Latency: strobes are combinational from the count; count held at 0 while en is low.
// Backpressure: none.
module uart_bit_timer #(
    parameter int OVERSAMPLE = 16
) (
    input  logic clk16,
    input  logic rst,
    input  logic en,
    output logic bit_start,
    output logic bit_end
);
    localparam int              CNT_W = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(OVERSAMPLE - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (!en || cnt_q == LAST) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk16) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_start = en && (cnt_q == '0);
    assign bit_end   = en && (cnt_q == LAST);
endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: start, DATA_W bits LSB first, optional parity (UART_TX_PARITY_EN), 1-2 stop bits.
// Latency: handshake at edge N -> start bit on the line from edge N+1; frames chain with no idle gap.
// Backpressure: one-entry holding register; tx_ready low while it is full.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int STOP_BITS   = 1,
    parameter int PARITY_MODE = PAR_NONE
) (
    input  logic            clk16,
    input  logic            rst,
    uart_tx_frame_if.slave  tx_if,
    output logic            serial_data,
    output logic            tx_busy,
    output logic            tx_end,
    output logic            clk_tx
);
    localparam int               IDX_W     = $clog2(DATA_W);
    localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_W - 1);
    localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);
`ifdef UART_TX_PARITY_EN
    localparam bit PAR_ACT = (PARITY_MODE != PAR_NONE);
`else
    localparam bit PAR_ACT = 1'b0;
`endif

    if (DATA_W < 5 || DATA_W > 9 || OVERSAMPLE < 4 || OVERSAMPLE > 64 ||
        STOP_BITS < 1 || STOP_BITS > 2 || PARITY_MODE < PAR_NONE || PARITY_MODE > PAR_ODD) begin : g_bad_cfg
        $error("uart_tx_frame: illegal parameter value");
    end

    tx_state_t         state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              hold_full_q, hold_full_d;
    logic              load;
    logic              bit_start, bit_end;

    uart_bit_timer #(.OVERSAMPLE(OVERSAMPLE)) u_bit_timer (
        .clk16     (clk16),
        .rst       (rst),
        .en        (state_q != IDLE),
        .bit_start (bit_start),
        .bit_end   (bit_end)
    );

    // idx_q counts data bits in DATA and stop bits in STOP.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        load    = 1'b0;
        case (state_q)
            IDLE: if (hold_full_q) begin
                state_d = START;
                load    = 1'b1;
            end
            START: if (bit_end) begin
                state_d = DATA;
                idx_d   = '0;
            end
            DATA: if (bit_end) begin
                shift_d = shift_q >> 1;
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST_DATA) begin
                    idx_d   = '0;
                    state_d = PAR_ACT ? PARITY : STOP;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (bit_end) begin
                state_d = STOP;
                idx_d   = '0;
            end
`endif
            STOP: if (bit_end) begin
                idx_d = idx_q + 1'b1;
                if (idx_q == LAST_STOP) begin
                    idx_d = '0;
                    if (hold_full_q) begin
                        state_d = START;
                        load    = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            shift_d = hold_q;
        end

        // Load (needs full) and capture (needs empty) can never coincide.
        hold_full_d = hold_full_q;
        hold_d      = hold_q;
        if (load) begin
            hold_full_d = 1'b0;
        end
        if (tx_if.tx_valid && !hold_full_q) begin
            hold_full_d = 1'b1;
            hold_d      = tx_if.tx_data;
        end
    end

    always_ff @(posedge clk16) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
        end
    end

`ifdef UART_TX_PARITY_EN
    logic par_q, par_d;

    // Parity is taken from the word as it leaves the holding register.
    always_comb begin
        par_d = par_q;
        if (load) begin
            par_d = (^hold_q) ^ (PARITY_MODE == PAR_ODD);
        end
    end

    always_ff @(posedge clk16) begin
        if (rst) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end
`endif

    always_comb begin
        serial_data = 1'b1;
        case (state_q)
            START:   serial_data = 1'b0;
            DATA:    serial_data = shift_q[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  serial_data = par_q;
`endif
            default: serial_data = 1'b1;
        endcase
    end

    assign tx_if.tx_ready = !hold_full_q;
    assign tx_busy        = (state_q != IDLE);
    assign clk_tx         = bit_start;
    assign tx_end         = (state_q == STOP) && (idx_q == LAST_STOP) && bit_end;
endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: four parameter sets, directed frames plus random traffic.
// Expected line values come from a bit-index frame model and a word scoreboard.
module tb_uart_tx_frame;
    localparam int NCFG = 4;
    localparam int CFG_DW [NCFG] = '{8, 7, 7, 8};
    localparam int CFG_OS [NCFG] = '{16, 4, 4, 4};
    localparam int CFG_SB [NCFG] = '{1, 2, 1, 2};
    localparam int CFG_PM [NCFG] = '{0, 2, 1, 0};

    logic            clk;
    logic            rst;
    logic [NCFG-1:0] vld;
    logic [8:0]      dat;
    logic [NCFG-1:0] ser, rdy, busy, tend, ctx;

    int sel;
    int n_chk;
    int n_pass;
    int end_cnt;
    int sb_q[$];
    int gap_q[$];
    int rdy0_q[$];
    int rdyl_q[$];
    int obs[16];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < NCFG; g++) begin : g_dut
        uart_tx_frame_if #(.DATA_W(CFG_DW[g])) ifc ();
        assign ifc.tx_valid = vld[g];
        assign ifc.tx_data  = dat[CFG_DW[g]-1:0];
        assign rdy[g]       = ifc.tx_ready;

        uart_tx_frame #(
            .DATA_W      (CFG_DW[g]),
            .OVERSAMPLE  (CFG_OS[g]),
            .STOP_BITS   (CFG_SB[g]),
            .PARITY_MODE (CFG_PM[g])
        ) dut (
            .clk16       (clk),
            .rst         (rst),
            .tx_if       (ifc.slave),
            .serial_data (ser[g]),
            .tx_busy     (busy[g]),
            .tx_end      (tend[g]),
            .clk_tx      (ctx[g])
        );
    end

    always @(posedge clk) end_cnt <= end_cnt + int'(tend[sel]);

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    function automatic int par_active(input int s);
`ifdef UART_TX_PARITY_EN
        return (CFG_PM[s] != 0) ? 1 : 0;
`else
        return 0;
`endif
    endfunction

    function automatic int frame_bits(input int s);
        return 1 + CFG_DW[s] + par_active(s) + CFG_SB[s];
    endfunction

    // Line value of bit b of a frame carrying word w.
    function automatic logic model_bit(input int s, input int w, input int b);
        int dw;
        int ones;
        dw = CFG_DW[s];
        if (b == 0) return 1'b0;
        if (b <= dw) return w[b-1];
        if (par_active(s) != 0 && b == dw + 1) begin
            ones = $countones(w & ((1 << dw) - 1));
            return ((ones % 2) == 1) ^ (CFG_PM[s] == 2);
        end
        return 1'b1;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        vld = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        sb_q.delete();
        gap_q.delete();
        rdy0_q.delete();
        rdyl_q.delete();
    endtask

    task automatic send(input int w);
        int t;
        t = 0;
        vld[sel] = 1'b1;
        dat = 9'(w);
        while (!rdy[sel] && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (!rdy[sel]) begin
            check("ready_timeout", 0, 1);
            vld[sel] = 1'b0;
            return;
        end
        @(posedge clk);
        sb_q.push_back(w & ((1 << CFG_DW[sel]) - 1));
        #1;
        vld[sel] = 1'b0;
        dat = 9'($urandom);
    endtask

    task automatic mon(input int nfr);
        for (int f = 0; f < nfr; f++) begin
            int w, gap, os, len, le, ce, ee, be;
            gap = 0;
            while (!busy[sel] && gap < 3000) begin
                @(negedge clk);
                gap++;
            end
            if (!busy[sel]) begin
                check("frame_start_timeout", 0, 1);
                return;
            end
            if (sb_q.size() == 0) begin
                check("frame_without_word", 0, 1);
                return;
            end
            w   = sb_q.pop_front();
            os  = CFG_OS[sel];
            len = os * frame_bits(sel);
            le = 0; ce = 0; ee = 0; be = 0;
            gap_q.push_back(gap);
            rdy0_q.push_back(int'(rdy[sel]));
            for (int c = 0; c < len; c++) begin
                if (c % os == os / 2) obs[c / os] = int'(ser[sel]);
                if (ser[sel] !== model_bit(sel, w, c / os)) le++;
                if (ctx[sel] !== (c % os == 0)) ce++;
                if (tend[sel] !== (c == len - 1)) ee++;
                if (busy[sel] !== 1'b1) be++;
                if (c == len - 1) rdyl_q.push_back(int'(rdy[sel]));
                @(negedge clk);
            end
            check("line_errors", le, 0);
            check("clk_tx_errors", ce, 0);
            check("tx_end_errors", ee, 0);
            check("busy_errors", be, 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_seq[10] = '{0, 0, 1, 1, 1, 0, 0, 0, 1, 1};
        int e0, idle_busy, t, len, pulses, ones;
        int line_v[200];
        n_chk = 0; n_pass = 0; end_cnt = 0;
        sel = 0; rst = 1'b1; vld = '0; dat = '0;

        // Reset state, then the reference frame 8'b1000_1110.
        do_reset();
        check("rst_serial_data", int'(ser[0]), 1);
        check("rst_tx_ready", int'(rdy[0]), 1);
        check("rst_tx_busy", int'(busy[0]), 0);
        check("rst_tx_end", int'(tend[0]), 0);
        check("rst_clk_tx", int'(ctx[0]), 0);
        e0 = end_cnt;
        fork
            send(8'h8E);
            mon(1);
        join
        for (int i = 0; i < 10; i++) check($sformatf("seq_bit%0d", i), obs[i], exp_seq[i]);
        check("tx_end_count", end_cnt - e0, 1);

        // Back-to-back 0xA5 then 0x3C.
        do_reset();
        fork
            begin send(8'hA5); send(8'h3C); end
            mon(2);
        join
        check("b2b_gap", (gap_q.size() == 2) ? gap_q[1] : -1, 0);
        check("b2b_ready_before_load", (rdyl_q.size() == 2) ? rdyl_q[0] : -1, 0);
        check("b2b_ready_after_load", (rdy0_q.size() == 2) ? rdy0_q[1] : -1, 1);

        // Reset during data bit 3 with a second word pending.
        do_reset();
        e0 = end_cnt;
        send(8'h5A);
        send(8'hC3);
        @(negedge clk);
        repeat (69) @(negedge clk);
        check("pre_rst_bit3", int'(ser[0]), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_serial_data", int'(ser[0]), 1);
        check("mid_rst_tx_ready", int'(rdy[0]), 1);
        check("mid_rst_tx_busy", int'(busy[0]), 0);
        idle_busy = 0;
        repeat (200) begin
            @(negedge clk);
            idle_busy += int'(busy[0]);
        end
        check("post_rst_busy_cycles", idle_busy, 0);
        check("post_rst_tx_end", end_cnt - e0, 0);
        sb_q.delete();
        fork
            send(8'h96);
            mon(1);
        join

        // Parity: DATA_W=7, 7'h55, odd then even.
        sel = 1;
        do_reset();
        fork send(7'h55); mon(1); join
`ifdef UART_TX_PARITY_EN
        check("odd_parity_bit", obs[8], 1);
`else
        check("bit8_is_stop", obs[8], 1);
`endif
        sel = 2;
        do_reset();
        fork send(7'h55); mon(1); join
`ifdef UART_TX_PARITY_EN
        check("even_parity_bit", obs[8], 0);
`else
        check("bit8_is_stop", obs[8], 1);
`endif

        // Two stop bits, OVERSAMPLE=4: frame length, tick count, trailing stop level.
        sel = 3;
        do_reset();
        send(8'h3F);
        t = 0;
        while (!busy[3] && t < 50) begin @(negedge clk); t++; end
        len = 0; pulses = 0;
        while (busy[3] && len < 200) begin
            line_v[len] = int'(ser[3]);
            pulses += int'(ctx[3]);
            len++;
            @(negedge clk);
        end
        check("stop2_frame_len", len, CFG_OS[3] * (1 + CFG_DW[3] + CFG_SB[3]));
        check("stop2_clk_tx_pulses", pulses, 11);
        ones = 0;
        for (int i = 0; i < 8; i++) if (len >= 8) ones += line_v[len - 8 + i];
        check("stop2_trailing_high", ones, 8);

        // Random traffic on every configuration, gaps from none to a full frame.
        for (int s = 0; s < NCFG; s++) begin
            sel = s;
            do_reset();
            fork
                begin
                    for (int i = 0; i < 8; i++) begin
                        int pick;
                        pick = $urandom_range(0, 4);
                        if (pick == 3) repeat (3) @(negedge clk);
                        if (pick == 4) repeat (CFG_OS[s] * frame_bits(s) + 2) @(negedge clk);
                        send($urandom);
                    end
                end
                mon(8);
            join
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
